// File: rtl/pw_candidate_gen_pkg.sv
// Shared candidate-generator constants: charset table (a-z, A-Z, 0-9), FSM encoding, length limit.
package pwcrack_pkg;

  localparam int MAX_LEN_LIMIT   = 32;
  localparam int CHARSET_ENTRIES = 62;
  localparam int IDX_W           = 6;

  // Entry 0 lands in the most significant byte of the literal, so index 0 is 'a'.
  localparam logic [0:CHARSET_ENTRIES-1][7:0] CHARSET =
    "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_STREAM    = 3'd2,
    ST_WAIT_HASH = 3'd3,
    ST_ADVANCE   = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  function automatic logic [7:0] charset_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (int'(idx) < CHARSET_ENTRIES) b = CHARSET[idx];
    return b;
  endfunction

endpackage

// File: rtl/pw_candidate_gen_if.sv
// Control, hash-core handshake and candidate-export signals of pw_candidate_gen.
// slave is the generator side; master is the host / hash-core side.
interface pw_candidate_gen_if #(
  parameter int MAX_LEN = 8
);
  logic                 START_IN;
  logic                 STOP_IN;
  logic [7:0]           MIN_LEN_IN;
  logic [7:0]           MAX_LEN_IN;
  logic                 BUSY_OUT;
  logic                 DONE_OUT;
  logic                 EXHAUSTED_OUT;
  logic                 HASH_START_OUT;
  logic [63:0]          HASH_SIZE_OUT;
  logic                 HASH_DONE_IN;
  logic [7:0]           BYTE_OUT;
  logic                 BYTE_VALID_OUT;
  logic                 BYTE_READ_IN;
  logic [8*MAX_LEN-1:0] CAND_OUT;
  logic [7:0]           CAND_LEN_OUT;
  logic [63:0]          CAND_COUNT_OUT;

  modport slave (
    input  START_IN, STOP_IN, MIN_LEN_IN, MAX_LEN_IN, HASH_DONE_IN, BYTE_READ_IN,
    output BUSY_OUT, DONE_OUT, EXHAUSTED_OUT, HASH_START_OUT, HASH_SIZE_OUT,
           BYTE_OUT, BYTE_VALID_OUT, CAND_OUT, CAND_LEN_OUT, CAND_COUNT_OUT
  );

  modport master (
    output START_IN, STOP_IN, MIN_LEN_IN, MAX_LEN_IN, HASH_DONE_IN, BYTE_READ_IN,
    input  BUSY_OUT, DONE_OUT, EXHAUSTED_OUT, HASH_START_OUT, HASH_SIZE_OUT,
           BYTE_OUT, BYTE_VALID_OUT, CAND_OUT, CAND_LEN_OUT, CAND_COUNT_OUT
  );
endinterface

// File: rtl/pw_candidate_gen_odometer.sv
// Charset index odometer: position len-1 is least significant, carry ripples toward position 0.
// Steps on step_i; wrap_o is high when the next step would roll every active position back to 0.
module cand_odometer
  import pwcrack_pkg::*;
#(
  parameter int MAX_LEN      = 8,
  parameter int CHARSET_SIZE = 62
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_i,
  input  logic                          step_i,
  input  logic [7:0]                    len_i,
  output logic [MAX_LEN-1:0][IDX_W-1:0] idx_o,
  output logic                          wrap_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARSET_SIZE - 1);

  logic [MAX_LEN-1:0][IDX_W-1:0] idx_q;
  logic [MAX_LEN-1:0][IDX_W-1:0] idx_d;
  logic                          carry;

  // Positions at or beyond len_i are never touched, so they stay 0 for the next length.
  always_comb begin
    idx_d = idx_q;
    carry = 1'b1;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if ((i < int'(len_i)) && carry) begin
        if (idx_q[i] == IDX_LAST) begin
          idx_d[i] = '0;
        end else begin
          idx_d[i] = idx_q[i] + IDX_W'(1);
          carry    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
    end else if (step_i) begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign wrap_o = carry;

endmodule

// File: rtl/pw_candidate_gen.sv
// Brute-force candidate generator feeding MD4: one hash launch per candidate, bytes stall on BYTE_READ_IN.
// START to HASH_START is one cycle, HASH_DONE to next launch two; launch counter only with CANDGEN_COUNT_EN.
module pw_candidate_gen
  import pwcrack_pkg::*;
#(
  parameter int MAX_LEN      = 8,
  parameter int CHARSET_SIZE = 62
) (
  input logic               CLK,
  input logic               RESET_N,
  pw_candidate_gen_if.slave bus
);

  localparam int LEN_CAP = (MAX_LEN < MAX_LEN_LIMIT) ? MAX_LEN : MAX_LEN_LIMIT;

  state_t     state_q;
  logic       busy_q;
  logic       done_q;
  logic       exh_q;
  logic       hash_start_q;
  logic       byte_valid_q;
  logic       stop_q;
  logic [7:0] len_q;
  logic [7:0] max_len_q;
  logic [7:0] ptr_q;

  logic [7:0] min_len_c;
  logic [7:0] max_len_c;
  logic       start_acc;
  logic       last_byte;
  logic       overflow;
  logic       step;
  logic       wrap;
  logic [MAX_LEN-1:0][IDX_W-1:0] idx;
  logic [8*MAX_LEN-1:0]          cand;
  logic [7:0]                    cur_byte;

  assign min_len_c = (bus.MIN_LEN_IN == 8'd0) ? 8'd1 : bus.MIN_LEN_IN;
  assign max_len_c = (bus.MAX_LEN_IN > 8'(LEN_CAP)) ? 8'(LEN_CAP) : bus.MAX_LEN_IN;
  assign start_acc = (state_q == ST_IDLE) && bus.START_IN;
  assign last_byte = (ptr_q == len_q - 8'd1);
  assign overflow  = wrap && (len_q == max_len_q);
  // Terminal advances leave the odometer alone so CAND_OUT keeps the last launched candidate.
  assign step      = (state_q == ST_ADVANCE) && !stop_q && !overflow;

  cand_odometer #(
    .MAX_LEN      (MAX_LEN),
    .CHARSET_SIZE (CHARSET_SIZE)
  ) u_odometer (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .clear_i (start_acc),
    .step_i  (step),
    .len_i   (len_q),
    .idx_o   (idx),
    .wrap_o  (wrap)
  );

  always_comb begin
    cand     = '0;
    cur_byte = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_q)) cand[i*8 +: 8] = charset_byte(idx[i]);
      if (i == int'(ptr_q)) cur_byte = cand[i*8 +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      exh_q        <= 1'b0;
      hash_start_q <= 1'b0;
      byte_valid_q <= 1'b0;
      stop_q       <= 1'b0;
      len_q        <= 8'd0;
      max_len_q    <= 8'd0;
      ptr_q        <= 8'd0;
    end else begin
      hash_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (busy_q && bus.STOP_IN) stop_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.START_IN) begin
            exh_q  <= 1'b0;
            stop_q <= 1'b0;
            ptr_q  <= 8'd0;
            if (min_len_c > max_len_c) begin
              len_q   <= 8'd0;
              done_q  <= 1'b1;
              exh_q   <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              len_q        <= min_len_c;
              max_len_q    <= max_len_c;
              busy_q       <= 1'b1;
              hash_start_q <= 1'b1;
              state_q      <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          byte_valid_q <= 1'b1;
          ptr_q        <= 8'd0;
          state_q      <= ST_STREAM;
        end
        ST_STREAM: begin
          if (byte_valid_q && bus.BYTE_READ_IN) begin
            if (last_byte) begin
              byte_valid_q <= 1'b0;
              state_q      <= ST_WAIT_HASH;
            end else begin
              ptr_q <= ptr_q + 8'd1;
            end
          end
        end
        ST_WAIT_HASH: begin
          if (bus.HASH_DONE_IN) state_q <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (stop_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            exh_q   <= 1'b0;
            state_q <= ST_FINISH;
          end else if (overflow) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            exh_q   <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            if (wrap) len_q <= len_q + 8'd1;
            hash_start_q <= 1'b1;
            state_q      <= ST_LAUNCH;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CANDGEN_COUNT_EN
  logic [63:0] count_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= 64'd0;
    end else if (start_acc) begin
      count_q <= 64'd0;
    end else if (state_q == ST_LAUNCH) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign bus.CAND_COUNT_OUT = count_q;
`else
  assign bus.CAND_COUNT_OUT = 64'd0;
`endif

  assign bus.BUSY_OUT       = busy_q;
  assign bus.DONE_OUT       = done_q;
  assign bus.EXHAUSTED_OUT  = exh_q;
  assign bus.HASH_START_OUT = hash_start_q;
  assign bus.HASH_SIZE_OUT  = {56'd0, len_q};
  assign bus.BYTE_OUT       = byte_valid_q ? cur_byte : 8'h00;
  assign bus.BYTE_VALID_OUT = byte_valid_q;
  assign bus.CAND_OUT       = cand;
  assign bus.CAND_LEN_OUT   = len_q;

endmodule
